random_delay_timer: RTL
=======================

RANDOM_DELAY_TIMER -- requirements
Module: random_delay_timer

Parameters
REQ-001 The block SHALL have parameter LFSR_W, default 13, giving the LFSR width in bits.
REQ-002 The block SHALL have parameter MIN_MS, default 250, giving the minimum delay in ticks.
REQ-003 The block SHALL have parameter MAX_MS, default 3000, giving the maximum delay in ticks.

Interface
REQ-004 sysclk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 tick  input  1  one-sysclk pulse per millisecond.
REQ-007 en_lfsr  input  1  advance the LFSR in each sysclk cycle it is high.
REQ-008 start_delay  input  1  single-cycle request to start a random delay.
REQ-009 time_out  output  1  single-cycle pulse when the delay expires.
REQ-010 busy  output  1  high while a delay is armed or counting.
REQ-011 delay_ms  output  12  delay value loaded for the current or most recent delay.

Function
REQ-012 The LFSR SHALL be LFSR_W bits, shift left, with new LSB = lfsr[12]^lfsr[3]^lfsr[2]^lfsr[0], and a period of 8191.
REQ-013 The LFSR SHALL advance in every cycle en_lfsr=1, in every state, and SHALL hold otherwise.
REQ-014 The LFSR SHALL never reach zero.
REQ-015 The FSM SHALL have states IDLE, COUNT and DONE.
REQ-016 IDLE + start_delay=1 SHALL go to COUNT and capture the pre-shift lfsr[11:0] that cycle as raw.
REQ-017 The load value SHALL be MIN_MS if raw < MIN_MS, MAX_MS if raw > MAX_MS, otherwise raw.
REQ-018 The load value SHALL be written to both the countdown counter and delay_ms.
REQ-019 In COUNT, each tick=1 SHALL decrement the counter by 1.
REQ-020 A tick while the counter = 1 SHALL move to DONE; the counter SHALL never wrap below 0.
REQ-021 DONE SHALL assert time_out=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-022 time_out SHALL rise exactly N ticks after start for load value N, registered with 1 sysclk latency after the Nth tick.
REQ-023 busy SHALL be 1 in COUNT and DONE and 0 in IDLE.
REQ-024 delay_ms SHALL hold its value until the next accepted start.
REQ-025 start_delay and tick high in the same cycle in IDLE SHALL load the counter with that tick not counted.
REQ-026 start_delay in COUNT or DONE SHALL be ignored, with no restart and no re-capture.
REQ-027 tick in IDLE or DONE SHALL have no effect.
REQ-028 en_lfsr=1 together with an accepted start SHALL capture the current value and shift the LFSR in the same edge.

Reset
REQ-029 rst=1 SHALL force state=IDLE, lfsr=1, counter=0, delay_ms=0, time_out=0, busy=0, immediately and independent of sysclk.
REQ-030 rst asserted mid-COUNT SHALL abort the delay with no time_out pulse, including after release.
REQ-031 After rst deasserts, the first accepted start SHALL behave as from power-up.

Structure
REQ-032 A shared package f1_pkg SHALL hold the state enum (IDLE, COUNT, DONE) and the constants LFSR_W, MIN_MS, MAX_MS and the tap positions.
REQ-033 The LFSR SHALL be a separate sub-module lfsr13 (ports sysclk, rst, en, q[12:0]); the FSM, clamp and counter SHALL live in random_delay_timer.
REQ-034 All registers SHALL use one always_ff each with async rst.
REQ-035 Next-state logic SHALL be an always_comb with a default assignment for every output and next-state.

Verification
REQ-036 Reset then start_delay with en_lfsr=0 (lfsr=1, clamped) -> delay_ms=250, busy=1, time_out pulses once, 1 cycle after the 250th tick, then busy=0.
REQ-037 en_lfsr=1 for 8191 cycles from reset -> lfsr returns to 1 with no zero state seen; the bench model matches every value.
REQ-038 Force raw=1000 via a model-predicted en_lfsr count, then start -> delay_ms=1000 and time_out after exactly 1000 ticks; raw=4000 -> delay_ms=3000.
REQ-039 start_delay repeated at ticks 10 and 100 of a 250-tick delay -> ignored; a single time_out at tick 250; delay_ms unchanged.
REQ-040 start_delay and tick in the same cycle -> time_out after N further ticks, not N-1.
REQ-041 rst pulse at tick 100 of a count -> busy=0 within the same cycle, no time_out for 300 ticks after release, lfsr=1.

Source files
------------

// File: rtl/f1_pkg.sv
// Shared definitions for the random delay timer: FSM states, default
// sizing, LFSR tap positions and the delay clamp helper.
package f1_pkg;

    localparam int LFSR_W = 13;
    localparam int MIN_MS = 250;
    localparam int MAX_MS = 3000;
    localparam int DLY_W  = 12;

    // Feedback taps of the 13-bit left-shifting LFSR (maximal length, 8191)
    localparam int TAP_A = 12;
    localparam int TAP_B = 3;
    localparam int TAP_C = 2;
    localparam int TAP_D = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Limit a raw random value to the [lo, hi] delay window
    function automatic logic [DLY_W-1:0] clamp_delay(
        input logic [DLY_W-1:0] raw,
        input logic [DLY_W-1:0] lo,
        input logic [DLY_W-1:0] hi
    );
        logic [DLY_W-1:0] res;
        if (raw < lo) begin
            res = lo;
        end else if (raw > hi) begin
            res = hi;
        end else begin
            res = raw;
        end
        return res;
    endfunction

endpackage

// File: rtl/lfsr13.sv
// Free-running Fibonacci LFSR, shifting left, advanced only while en is high.
// Resets to 1; a zero state (unreachable in normal use) is forced back to 1.
module lfsr13
    import f1_pkg::*;
#(
    parameter int W = f1_pkg::LFSR_W
) (
    input  logic         sysclk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next LFSR value: shift left and insert the tap parity as the new LSB
    always_comb begin
        q_d = {q_q[W-2:0], q_q[TAP_A] ^ q_q[TAP_B] ^ q_q[TAP_C] ^ q_q[TAP_D]};
        if (q_q == '0) begin
            q_d = W'(1);
        end
    end

    // LFSR state register, holds when not enabled
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            q_q <= W'(1);
        end else if (en) begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/random_delay_timer.sv
// Random delay timer: on a start request captures the LFSR, clamps it to
// [MIN_MS, MAX_MS] and counts that many ticks, then pulses time_out.
module random_delay_timer
    import f1_pkg::*;
#(
    parameter int LFSR_W = f1_pkg::LFSR_W,
    parameter int MIN_MS = f1_pkg::MIN_MS,
    parameter int MAX_MS = f1_pkg::MAX_MS
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en_lfsr,
    input  logic             start_delay,
    output logic             time_out,
    output logic             busy,
    output logic [DLY_W-1:0] delay_ms
);

    localparam logic [DLY_W-1:0] MIN_L = DLY_W'(MIN_MS);
    localparam logic [DLY_W-1:0] MAX_L = DLY_W'(MAX_MS);

    logic [LFSR_W-1:0] lfsr_q;
    logic [DLY_W-1:0]  raw;
    logic [DLY_W-1:0]  load_val;
    logic [LFSR_W-1:DLY_W] unused_lfsr_hi;

    state_t           state_q,    state_d;
    logic [DLY_W-1:0] cnt_q,      cnt_d;
    logic [DLY_W-1:0] delay_q,    delay_d;
    logic             time_out_q, time_out_d;
    logic             busy_q,     busy_d;

    lfsr13 #(.W(LFSR_W)) u_lfsr (
        .sysclk (sysclk),
        .rst    (rst),
        .en     (en_lfsr),
        .q      (lfsr_q)
    );

    // The pre-shift value is sampled, so a simultaneous shift does not affect capture
    assign raw            = lfsr_q[DLY_W-1:0];
    assign unused_lfsr_hi = lfsr_q[LFSR_W-1:DLY_W];
    assign load_val       = clamp_delay(raw, MIN_L, MAX_L);

    // FSM next-state, counter and output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        delay_d    = delay_q;
        time_out_d = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start_delay) begin
                    state_d = COUNT;
                    cnt_d   = load_val;
                    delay_d = load_val;
                    busy_d  = 1'b1;
                end
            end
            COUNT: begin
                busy_d = 1'b1;
                if (tick) begin
                    // <= 1 keeps the counter from ever wrapping below zero
                    if (cnt_q <= DLY_W'(1)) begin
                        state_d    = DONE;
                        cnt_d      = '0;
                        time_out_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - DLY_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Countdown counter
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded delay value, held until the next accepted start
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            delay_q <= '0;
        end else begin
            delay_q <= delay_d;
        end
    end

    // Registered single-cycle expiry pulse, coincident with DONE
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            time_out_q <= 1'b0;
        end else begin
            time_out_q <= time_out_d;
        end
    end

    // Registered busy flag, high in COUNT and DONE
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign time_out = time_out_q;
    assign busy     = busy_q;
    assign delay_ms = delay_q;

endmodule
